// File: rtl/sd30xx_rtc_writer.sv
// Purpose : programs SD30xx RTC time/date via unlock, data write, lock byte sequence.
// Latency : 1 LATCH + steps*(1 + master write time + GAP_CYC) + 1 DONE cycle per request.
// Backpres: holds each byte in ISSUE while i2c_busy; requests are level-held until set_done.
module sd30xx_rtc_writer #(
    parameter logic [6:0] DEV_ADDR  = 7'h32,
    parameter int         GAP_CYC   = 16,
    parameter int         MAX_RETRY = 3
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        set_time,
    input  logic [23:0] time_2_set,
    input  logic        set_date,
    input  logic [31:0] date_2_set,
    output logic        set_done,
    output logic        wr_err,
    output logic        busy,
    output logic        i2c_req,
    output logic [6:0]  i2c_dev,
    output logic [7:0]  i2c_reg,
    output logic [7:0]  i2c_wdata,
    input  logic        i2c_busy,
    input  logic        i2c_done,
    input  logic        i2c_nack
);

    localparam int RW = $clog2(MAX_RETRY + 2);
    localparam int GW = $clog2(GAP_CYC + 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
    localparam logic [GW-1:0] GAP_LOAD  = GW'(GAP_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_ISSUE,
        S_WAIT,
        S_GAP,
        S_DONE
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            job_date;   // 0: time job, 1: date job
    logic [31:0]     data;       // request vector frozen at LATCH
    logic [2:0]      step;
    logic [RW-1:0]   retry;
    logic [GW-1:0]   gap_cnt;
    logic            restart;    // GAP follows a NACK: re-issue step 0 without incrementing
    logic            guard;      // blocks request sampling in the cycle right after DONE
    logic [7:0]      tbl_reg;
    logic [7:0]      tbl_dat;
    logic [2:0]      last_step;

    assign i2c_dev = DEV_ADDR;

    // Register/data lookup for the current step of the active job.
    always_comb begin
        tbl_reg   = 8'h00;
        tbl_dat   = 8'h00;
        last_step = job_date ? 3'd7 : 3'd6;
        case (step)
            3'd0: begin tbl_reg = 8'h10; tbl_dat = 8'h80; end
            3'd1: begin tbl_reg = 8'h0F; tbl_dat = 8'h84; end
            3'd2: begin tbl_reg = job_date ? 8'h03 : 8'h00; tbl_dat = data[7:0];  end
            3'd3: begin tbl_reg = job_date ? 8'h04 : 8'h01; tbl_dat = data[15:8]; end
            3'd4: begin
                tbl_reg = job_date ? 8'h05 : 8'h02;
                tbl_dat = job_date ? data[23:16] : {1'b1, data[22:16]};
            end
            3'd5: begin
                tbl_reg = job_date ? 8'h06 : 8'h0F;
                tbl_dat = job_date ? data[31:24] : 8'h00;
            end
            3'd6: begin tbl_reg = job_date ? 8'h0F : 8'h10; tbl_dat = 8'h00; end
            default: begin tbl_reg = 8'h10; tbl_dat = 8'h00; end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state decode and FSM-driven outputs.
    always_comb begin
        state_nxt = state;
        set_done  = 1'b0;
        busy      = (state != S_IDLE);
        i2c_req   = 1'b0;
        i2c_reg   = 8'h00;
        i2c_wdata = 8'h00;
        case (state)
            S_IDLE: begin
                if (!guard && (set_time || set_date)) state_nxt = S_LATCH;
            end
            S_LATCH: state_nxt = S_ISSUE;
            S_ISSUE: begin
                i2c_reg   = tbl_reg;
                i2c_wdata = tbl_dat;
                if (!i2c_busy) begin
                    i2c_req   = 1'b1;
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                i2c_reg   = tbl_reg;
                i2c_wdata = tbl_dat;
                if (i2c_done) begin
                    if (!i2c_nack || (retry < RETRY_MAX)) state_nxt = S_GAP;
                    else                                  state_nxt = S_DONE;
                end
            end
            S_GAP: begin
                if (gap_cnt == '0)
                    state_nxt = (!restart && (step == last_step)) ? S_DONE : S_ISSUE;
            end
            S_DONE: begin
                set_done  = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Job selection, step/retry/gap bookkeeping and sticky abort flag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            job_date <= 1'b0;
            data     <= 32'h0;
            step     <= 3'd0;
            retry    <= '0;
            gap_cnt  <= '0;
            restart  <= 1'b0;
            guard    <= 1'b0;
            wr_err   <= 1'b0;
        end else begin
            guard <= (state == S_DONE);
            case (state)
                S_IDLE: begin
                    if (state_nxt == S_LATCH) job_date <= !set_time;
                end
                S_LATCH: begin
                    data    <= job_date ? date_2_set : {8'h00, time_2_set};
                    step    <= 3'd0;
                    retry   <= '0;
                    restart <= 1'b0;
                end
                S_WAIT: begin
                    if (i2c_done) begin
                        if (!i2c_nack) begin
                            gap_cnt <= GAP_LOAD;
                        end else if (retry < RETRY_MAX) begin
                            retry   <= retry + 1'b1;
                            step    <= 3'd0;
                            restart <= 1'b1;
                            gap_cnt <= GAP_LOAD;
                        end else begin
                            wr_err  <= 1'b1;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_cnt != '0) begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end else if (state_nxt == S_ISSUE) begin
                        if (restart) restart <= 1'b0;
                        else         step    <= step + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sd30xx_rtc_writer.sv
// Bench for sd30xx_rtc_writer: vector table, hand corner sequences, random jobs.
// An I2C master model records every byte write; a spec-level model lists expected writes.
// Outputs are sampled on the falling clock edge; inputs change there or #1 after rise.
module tb_sd30xx_rtc_writer;

    localparam int         GAP  = 16;
    localparam int         MAXR = 3;
    localparam logic [6:0] DEV  = 7'h32;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        set_time = 1'b0;
    logic [23:0] time_2_set = 24'h0;
    logic        set_date = 1'b0;
    logic [31:0] date_2_set = 32'h0;
    logic        set_done, wr_err, busy, i2c_req;
    logic [6:0]  i2c_dev;
    logic [7:0]  i2c_reg, i2c_wdata;
    logic        i2c_busy, i2c_done;
    logic        i2c_nack = 1'b0;
    logic        m_busy = 1'b0, ext_busy = 1'b0, m_done = 1'b0, stray_done = 1'b0;

    assign i2c_busy = m_busy | ext_busy;
    assign i2c_done = m_done | stray_done;

    sd30xx_rtc_writer #(.DEV_ADDR(DEV), .GAP_CYC(GAP), .MAX_RETRY(MAXR)) dut (
        .clk(clk), .rstn(rstn),
        .set_time(set_time), .time_2_set(time_2_set),
        .set_date(set_date), .date_2_set(date_2_set),
        .set_done(set_done), .wr_err(wr_err), .busy(busy),
        .i2c_req(i2c_req), .i2c_dev(i2c_dev), .i2c_reg(i2c_reg), .i2c_wdata(i2c_wdata),
        .i2c_busy(i2c_busy), .i2c_done(i2c_done), .i2c_nack(i2c_nack)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int req_cnt = 0;
    int nack_mode = 0;   // 0 ack all, 1 nack the 4th write of the job once, 2 nack all
    int m_w = 1;         // master write time in cycles
    int wr_cnt = 0;
    logic [15:0] got_q[$];
    logic [15:0] exp_q[$];
    logic [15:0] m_cap;
    bit          m_abort;

    typedef struct {
        bit          is_date;
        logic [31:0] v;
        int          mode;
        int          w;
        int          exp_n;
        bit          exp_err;
    } vec_t;
    vec_t tbl[4];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Count set_done pulses and write starts.
    always @(negedge clk) begin
        if (set_done === 1'b1) done_cnt++;
        if (rstn && i2c_req === 1'b1) req_cnt++;
    end

    // I2C master model: records each write, answers after m_w cycles.
    initial begin
        forever begin
            @(negedge clk);
            if (rstn && i2c_req === 1'b1) begin
                m_cap = {i2c_reg, i2c_wdata};
                got_q.push_back(m_cap);
                chk("i2c_dev", 64'(i2c_dev), 64'(DEV));
                @(posedge clk);
                #1 m_busy = 1'b1;
                m_abort = 1'b0;
                for (int k = 1; k < m_w; k++) begin
                    @(negedge clk);
                    if (!rstn) begin m_abort = 1'b1; break; end
                end
                if (!m_abort) begin
                    @(negedge clk);
                    if (!rstn) m_abort = 1'b1;
                end
                if (!m_abort) begin
                    i2c_nack = (nack_mode == 2) || (nack_mode == 1 && wr_cnt == 3);
                    m_done = 1'b1;
                    chk("reg_stable", 64'({i2c_reg, i2c_wdata}), 64'(m_cap));
                    wr_cnt++;
                    @(negedge clk);
                    m_done = 1'b0;
                    i2c_nack = 1'b0;
                end
                m_busy = 1'b0;
            end
        end
    end

    // Expected write list straight from the register tables and retry rules.
    task automatic build_exp(input bit is_date, input logic [31:0] v, input int mode);
        logic [7:0] rg[8];
        logic [7:0] dt[8];
        int n;
        rg[0] = 8'h10; dt[0] = 8'h80;
        rg[1] = 8'h0F; dt[1] = 8'h84;
        if (!is_date) begin
            n = 7;
            rg[2] = 8'h00; dt[2] = v[7:0];
            rg[3] = 8'h01; dt[3] = v[15:8];
            rg[4] = 8'h02; dt[4] = {1'b1, v[22:16]};
            rg[5] = 8'h0F; dt[5] = 8'h00;
            rg[6] = 8'h10; dt[6] = 8'h00;
            rg[7] = 8'h00; dt[7] = 8'h00;
        end else begin
            n = 8;
            rg[2] = 8'h03; dt[2] = v[7:0];
            rg[3] = 8'h04; dt[3] = v[15:8];
            rg[4] = 8'h05; dt[4] = v[23:16];
            rg[5] = 8'h06; dt[5] = v[31:24];
            rg[6] = 8'h0F; dt[6] = 8'h00;
            rg[7] = 8'h10; dt[7] = 8'h00;
        end
        if (mode == 2) begin
            for (int i = 0; i <= MAXR; i++) exp_q.push_back({rg[0], dt[0]});
        end else begin
            if (mode == 1) for (int i = 0; i < 4; i++) exp_q.push_back({rg[i], dt[i]});
            for (int i = 0; i < n; i++) exp_q.push_back({rg[i], dt[i]});
        end
    endtask

    task automatic check_writes();
        int n;
        chk("n_writes", 64'(got_q.size()), 64'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk($sformatf("write%0d", i), 64'(got_q[i]), 64'(exp_q[i]));
    endtask

    task automatic wait_done(output bit found, output int cyc);
        found = 1'b0;
        cyc = 0;
        for (int i = 1; i <= 20000; i++) begin
            @(negedge clk);
            if (set_done === 1'b1) begin found = 1'b1; cyc = i; break; end
        end
    endtask

    task automatic run_job(input bit is_date, input logic [31:0] v, input int mode,
                           input int w, input int exp_n, input bit exp_err);
        bit found;
        int cyc;
        int d0;
        @(negedge clk);
        got_q.delete();
        exp_q.delete();
        wr_cnt = 0;
        nack_mode = mode;
        m_w = w;
        d0 = done_cnt;
        if (is_date) begin date_2_set = v; set_date = 1'b1; end
        else begin time_2_set = v[23:0]; set_time = 1'b1; end
        wait_done(found, cyc);
        set_time = 1'b0;
        set_date = 1'b0;
        chk("done_seen", 64'(found), 64'd1);
        if (mode == 0 && found) chk("latency", 64'(cyc), 64'(2 + (is_date ? 8 : 7) * (1 + w + GAP)));
        repeat (3) @(negedge clk);
        chk("done_pulses", 64'(done_cnt - d0), 64'd1);
        chk("busy_after", 64'(busy), 64'd0);
        chk("wr_err", 64'(wr_err), 64'(exp_err));
        if (exp_n >= 0) chk("n_writes_tbl", 64'(got_q.size()), 64'(exp_n));
        build_exp(is_date, v, mode);
        check_writes();
    endtask

    initial begin
        bit found;
        int cyc;
        int d0;
        int r0;

        tbl[0] = '{1'b0, 32'h00235959, 0, 20, 7, 1'b0};
        tbl[1] = '{1'b1, 32'h25123103, 0, 20, 8, 1'b0};
        tbl[2] = '{1'b0, 32'h00081503, 1, 5, 11, 1'b0};
        tbl[3] = '{1'b1, 32'h99010207, 0, 1, 8, 1'b0};

        // Reset state.
        #2 rstn = 1'b0;
        #3;
        chk("rst_set_done", 64'(set_done), 64'd0);
        chk("rst_wr_err", 64'(wr_err), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_i2c_req", 64'(i2c_req), 64'd0);
        chk("rst_i2c_reg", 64'(i2c_reg), 64'd0);
        chk("rst_i2c_wdata", 64'(i2c_wdata), 64'd0);
        chk("rst_i2c_dev", 64'(i2c_dev), 64'(DEV));
        repeat (3) @(negedge clk);
        rstn = 1'b1;

        // Table-driven jobs.
        for (int i = 0; i < 4; i++)
            run_job(tbl[i].is_date, tbl[i].v, tbl[i].mode, tbl[i].w, tbl[i].exp_n, tbl[i].exp_err);

        // Both requests high: time first, then date back-to-back after the guard cycle.
        @(negedge clk);
        got_q.delete();
        exp_q.delete();
        wr_cnt = 0;
        nack_mode = 0;
        m_w = 4;
        d0 = done_cnt;
        time_2_set = 24'h123456;
        date_2_set = 32'h30060501;
        set_time = 1'b1;
        set_date = 1'b1;
        wait_done(found, cyc);
        set_time = 1'b0;
        chk("both_first_done", 64'(found), 64'd1);
        chk("both_first_n", 64'(got_q.size()), 64'd7);
        wait_done(found, cyc);
        set_date = 1'b0;
        chk("both_second_done", 64'(found), 64'd1);
        chk("b2b_latency", 64'(cyc), 64'(4 + 8 * (1 + 4 + GAP)));
        repeat (3) @(negedge clk);
        chk("both_pulses", 64'(done_cnt - d0), 64'd2);
        build_exp(1'b0, 32'h00123456, 0);
        build_exp(1'b1, 32'h30060501, 0);
        check_writes();

        // Stray i2c_done while idle is ignored.
        @(negedge clk);
        r0 = req_cnt;
        stray_done = 1'b1;
        @(negedge clk);
        stray_done = 1'b0;
        repeat (10) @(negedge clk);
        chk("stray_busy", 64'(busy), 64'd0);
        chk("stray_req", 64'(req_cnt - r0), 64'd0);

        // Master busy: ISSUE holds the first byte without requesting.
        @(negedge clk);
        got_q.delete();
        exp_q.delete();
        wr_cnt = 0;
        nack_mode = 0;
        m_w = 2;
        d0 = done_cnt;
        r0 = req_cnt;
        ext_busy = 1'b1;
        time_2_set = 24'h010203;
        set_time = 1'b1;
        repeat (30) @(negedge clk);
        chk("hold_req", 64'(req_cnt - r0), 64'd0);
        chk("hold_busy", 64'(busy), 64'd1);
        chk("hold_reg", 64'({i2c_reg, i2c_wdata}), 64'h1080);
        @(posedge clk);
        #1 ext_busy = 1'b0;
        wait_done(found, cyc);
        set_time = 1'b0;
        chk("hold_done", 64'(found), 64'd1);
        repeat (3) @(negedge clk);
        chk("hold_pulses", 64'(done_cnt - d0), 64'd1);
        build_exp(1'b0, 32'h00010203, 0);
        check_writes();

        // Random jobs against the model.
        for (int r = 0; r < 6; r++) begin
            bit          is_d;
            logic [31:0] v;
            int          mode;
            int          w;
            is_d = 1'($urandom_range(0, 1));
            v    = $urandom;
            mode = int'($urandom_range(0, 1));
            w    = int'($urandom_range(1, 12));
            run_job(is_d, v, mode, w, -1, 1'b0);
        end

        // Persistent NACK: abort after MAX_RETRY restarts, wr_err sticky.
        run_job(1'b0, 32'h00112233, 2, 3, MAXR + 1, 1'b1);
        repeat (20) @(negedge clk);
        chk("wr_err_sticky", 64'(wr_err), 64'd1);

        // Reset in WAIT: outputs clear at once, no further writes.
        @(negedge clk);
        got_q.delete();
        wr_cnt = 0;
        nack_mode = 0;
        m_w = 200;
        time_2_set = 24'h101010;
        set_time = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (m_busy) begin found = 1'b1; break; end
        end
        chk("reach_wait", 64'(found), 64'd1);
        repeat (5) @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("arst_set_done", 64'(set_done), 64'd0);
        chk("arst_wr_err", 64'(wr_err), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_i2c_req", 64'(i2c_req), 64'd0);
        chk("arst_i2c_reg", 64'(i2c_reg), 64'd0);
        chk("arst_i2c_wdata", 64'(i2c_wdata), 64'd0);
        set_time = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        r0 = req_cnt;
        repeat (40) @(negedge clk);
        chk("post_rst_req", 64'(req_cnt - r0), 64'd0);
        chk("post_rst_busy", 64'(busy), 64'd0);

        // Fresh request after reset works normally.
        run_job(1'b1, 32'h24022904, 0, 3, 8, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sd30xx_rtc_writer.md
Name: sd30xx_rtc_writer

Overview:
- Consumes clock-set requests from the UART time-adjust stage and programs the SD30xx RTC over a byte-level I2C write master.
- Each request (time, or date) runs a write-unlock, data write, write-lock register sequence.
- Completion or abort is signalled by a single-cycle set_done pulse back to the request stage.
- Sits between the UART adjust stage and the shared I2C master in the rtc_hex path.

Parameters:
- DEV_ADDR, 7'h32, SD30xx 7-bit I2C slave address driven on i2c_dev.
- GAP_CYC, 16, idle clk cycles inserted after every completed byte write before the next request (min 1).
- MAX_RETRY, 3, full-sequence restarts allowed after a NACK before aborting.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- set_time  in  1  level request; held high by the requester until set_done
- time_2_set  in  24  BCD {HH,MM,SS}
- set_date  in  1  level request; held high by the requester until set_done
- date_2_set  in  32  BCD {YY,MM,DD,WW}
- set_done  out  1  one-cycle pulse: request finished or aborted
- wr_err  out  1  sticky; set on abort, cleared only by reset
- busy  out  1  high whenever FSM is not IDLE
- i2c_req  out  1  one-cycle write-start pulse
- i2c_dev  out  7  constant DEV_ADDR
- i2c_reg  out  8  register address, stable from i2c_req until i2c_done
- i2c_wdata  out  8  data byte, stable from i2c_req until i2c_done
- i2c_busy  in  1  I2C master occupied
- i2c_done  in  1  one-cycle pulse: byte write finished
- i2c_nack  in  1  valid only with i2c_done; 1 means slave NACK

Behaviour:
- Reset is rstn, asynchronous, active-low; clock is clk.
- Reset values: set_done=0, wr_err=0, busy=0, i2c_req=0, i2c_reg=0, i2c_wdata=0, FSM=IDLE, step=0, retry=0, gap counter=0.
- FSM states: IDLE, LATCH, ISSUE, WAIT, GAP, DONE.
- IDLE: if set_time=1, select TIME job; else if set_date=1, select DATE job. set_time wins if both are high. Go to LATCH.
- LATCH (1 cycle):
  - Capture the input vector into an internal register. Later input changes are ignored until DONE.
  - Set step=0 and retry=0.
- Step tables, listed as reg<=data. Hour byte = {1'b1, HH[6:0]} (24h mode).
  - TIME job, 7 steps: 0x10<=0x80, 0x0F<=0x84, 0x00<=SS, 0x01<=MM, 0x02<=hour byte, 0x0F<=0x00, 0x10<=0x00.
  - DATE job, 8 steps: 0x10<=0x80, 0x0F<=0x84, 0x03<=WW, 0x04<=DD, 0x05<=MM, 0x06<=YY, 0x0F<=0x00, 0x10<=0x00.
- ISSUE:
  - Drive i2c_reg and i2c_wdata for the current step.
  - Pulse i2c_req for exactly one cycle, in the first cycle where i2c_busy=0.
  - Stay in ISSUE while i2c_busy=1. Go to WAIT after the pulse.
- WAIT: hold i2c_reg and i2c_wdata until i2c_done.
  - i2c_done=1, i2c_nack=0: load gap counter with GAP_CYC-1 and go to GAP.
  - i2c_done=1, i2c_nack=1, retry<MAX_RETRY: retry+=1, step=0, go to GAP. The full sequence restarts, including unlock.
  - i2c_done=1, i2c_nack=1, retry==MAX_RETRY: set wr_err and go to DONE (abort). No lock writes are attempted.
- GAP: count down to 0. Then, if the last step of the job has completed, go to DONE; otherwise step+=1 (no increment after a NACK restart) and go to ISSUE.
- DONE: set_done=1 for exactly this cycle, then return to IDLE.
  - The requester deasserts its request on the next edge.
  - IDLE must not re-sample requests in the cycle immediately after DONE. A one-cycle guard covers this.
- Latency for a clean TIME job, measured from the set_time rise with i2c_busy=0 and a master write time of W cycles: 1 (LATCH) + 7×(1+W+GAP_CYC) + 1 (DONE).
- Back-to-back: the requester raises set_date after set_done. This block must accept it as a new DATE job with no lost cycles beyond the guard.
- i2c_done while not in WAIT is ignored.
- Reset mid-sequence returns to IDLE immediately with all outputs at reset values. No lock writes are issued.

Test Plan:
- set_time with time_2_set=24'h235959, master always ACKs after 20 cycles -> 7 writes in order: 10<=80, 0F<=84, 00<=59, 01<=59, 02<=A3, 0F<=00, 10<=00. One set_done pulse follows; wr_err=0.
- set_date with date_2_set=32'h25123103 -> 8 writes: 10<=80, 0F<=84, 03<=03, 04<=31, 05<=12, 06<=25, 0F<=00, 10<=00. Then set_done.
- set_time and set_date both high -> TIME job runs first. After set_done, with set_time dropped, the DATE job runs. Exactly two set_done pulses.
- NACK on step 3 once -> sequence restarts at 10<=80, completes with 7 ACKed writes after the retry, wr_err=0.
- NACK on every write with MAX_RETRY=3 -> 4 attempts of step 0 only, then set_done pulses, wr_err=1 (sticky), busy=0.
- rstn low during WAIT -> all outputs 0 asynchronously. After release, no i2c_req until a new request arrives.
